// File: rtl/flip_flops_pkg.sv
// Shared constants and per-bit next-state helpers for the flip_flops bank.
package flip_flops_pkg;

  // 2-bit control encodings, used as {j,k} and as {s,r}
  localparam logic [1:0] CTRL_HOLD = 2'b00;
  localparam logic [1:0] CTRL_CLR  = 2'b01;
  localparam logic [1:0] CTRL_SET  = 2'b10;
  localparam logic [1:0] CTRL_BOTH = 2'b11;

  // State value loaded by reset
  localparam logic RST_Q = 1'b0;

  // JK: both controls high toggles the bit
  function automatic logic jk_next(input logic [1:0] ctrl, input logic q);
    logic nxt;
    nxt = q;
    case (ctrl)
      CTRL_HOLD: nxt = q;
      CTRL_CLR:  nxt = 1'b0;
      CTRL_SET:  nxt = 1'b1;
      CTRL_BOTH: nxt = ~q;
      default:   nxt = q;
    endcase
    return nxt;
  endfunction

  // SR: the forbidden both-high case holds, so the state never goes X
  function automatic logic sr_next(input logic [1:0] ctrl, input logic q);
    logic nxt;
    nxt = q;
    case (ctrl)
      CTRL_HOLD: nxt = q;
      CTRL_CLR:  nxt = 1'b0;
      CTRL_SET:  nxt = 1'b1;
      CTRL_BOTH: nxt = q;
      default:   nxt = q;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/flip_flops_ff_cell.sv
// WIDTH-bit register with synchronous active-high reset to RST_Q.
// Ports: clk, rst (sync, active-high), d_i (next state), q_o (registered state).
module ff_cell
  import flip_flops_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  // State register; reset wins over the next-state input
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= {WIDTH{RST_Q}};
    end else begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/flip_flops.sv
// Bank of independent JK, SR, D and T flops sharing one clock and a
// synchronous active-high reset. Each flop drives a true output and a
// complement that is derived from the stored state.
// Ports: clk, rst; j/k -> q_jk/qb_jk; s/r -> q_sr/qb_sr; d -> q_d/qb_d;
//        t -> q_t/qb_t. All data ports are WIDTH bits, one flop per bit.
module flip_flops
  import flip_flops_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q_jk,
  output logic [WIDTH-1:0] qb_jk,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q_sr,
  output logic [WIDTH-1:0] qb_sr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q_d,
  output logic [WIDTH-1:0] qb_d,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q_t,
  output logic [WIDTH-1:0] qb_t
);

  logic [WIDTH-1:0] jk_q, jk_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] dd_q, dd_d;
  logic [WIDTH-1:0] tt_q, tt_d;

  // Per-bit next-state logic for all four flop types
  always_comb begin
    jk_d = jk_q;
    sr_d = sr_q;
    dd_d = d;
    tt_d = tt_q ^ t;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      jk_d[i] = jk_next({j[i], k[i]}, jk_q[i]);
      sr_d[i] = sr_next({s[i], r[i]}, sr_q[i]);
    end
  end

  ff_cell #(.WIDTH(WIDTH)) u_jk (.clk(clk), .rst(rst), .d_i(jk_d), .q_o(jk_q));
  ff_cell #(.WIDTH(WIDTH)) u_sr (.clk(clk), .rst(rst), .d_i(sr_d), .q_o(sr_q));
  ff_cell #(.WIDTH(WIDTH)) u_d  (.clk(clk), .rst(rst), .d_i(dd_d), .q_o(dd_q));
  ff_cell #(.WIDTH(WIDTH)) u_t  (.clk(clk), .rst(rst), .d_i(tt_d), .q_o(tt_q));

  assign q_jk  = jk_q;
  assign q_sr  = sr_q;
  assign q_d   = dd_q;
  assign q_t   = tt_q;

  // Complements come straight from the stored state so each pair cannot diverge
  assign qb_jk = ~jk_q;
  assign qb_sr = ~sr_q;
  assign qb_d  = ~dd_q;
  assign qb_t  = ~tt_q;

endmodule

// File: tb/tb_flip_flops.sv
// Directed bench: the stimulus process drives one vector per clock and pushes
// the hand-computed expected state; the monitor pops and compares after each edge.
module tb_flip_flops;

  localparam int unsigned WIDTH = 1;
  localparam int unsigned NVEC  = 21;

  logic clk, rst;
  logic [WIDTH-1:0] j, k, s, r, d, t;
  logic [WIDTH-1:0] q_jk, qb_jk, q_sr, qb_sr, q_d, qb_d, q_t, qb_t;

  // Inputs for one edge, a flag to pulse d between edges, then expected state
  typedef struct packed {
    logic rst, j, k, s, r, d, t, glitch;
    logic ejk, esr, ed, et;
  } vec_t;

  typedef struct packed {
    logic jk, sr, dd, tt;
    int unsigned idx;
  } exp_t;

  vec_t vecs [NVEC];
  exp_t sb_q [$];
  int n_checks = 0;
  int n_fail   = 0;
  bit stim_done = 1'b0;

  flip_flops #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .j(j), .k(k), .q_jk(q_jk), .qb_jk(qb_jk),
    .s(s), .r(r), .q_sr(q_sr), .qb_sr(qb_sr),
    .d(d), .q_d(q_d), .qb_d(qb_d),
    .t(t), .q_t(q_t), .qb_t(qb_t)
  );

  // First rising edge at t=20, period 20
  initial begin
    clk = 1'b0;
    #20;
    forever begin
      clk = 1'b1;
      #10;
      clk = 1'b0;
      #10;
    end
  end

  task automatic check1(input string name, input int unsigned idx,
                        input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec=%0d actual=%b expected=%b", name, idx, act, exp);
    end
  endtask

  // Stimulus: rows are {rst j k s r d t glitch | exp_jk exp_sr exp_d exp_t}
  initial begin
    vecs[0]  = vec_t'(12'b1000_0000_0000); // reset edge 20
    vecs[1]  = vec_t'(12'b1000_0000_0000); // reset edge 40
    vecs[2]  = vec_t'(12'b0000_0000_0000); // idle after reset
    vecs[3]  = vec_t'(12'b0000_0000_0000);
    vecs[4]  = vec_t'(12'b0010_1110_0011); // k=1 r=1 d=1 t=1
    vecs[5]  = vec_t'(12'b0010_1110_0010);
    vecs[6]  = vec_t'(12'b0010_1110_0011);
    vecs[7]  = vec_t'(12'b0101_0110_1110); // j=1 s=1
    vecs[8]  = vec_t'(12'b0101_0110_1111);
    vecs[9]  = vec_t'(12'b0111_1110_0110); // j=k=1 toggle, s=r=1 hold
    vecs[10] = vec_t'(12'b0111_1110_1111);
    vecs[11] = vec_t'(12'b0111_1110_0110);
    vecs[12] = vec_t'(12'b1111_1110_0000); // reset overrides d=1, toggles
    vecs[13] = vec_t'(12'b0111_1110_1011); // first edge after reset uses inputs
    vecs[14] = vec_t'(12'b0111_1110_0010);
    vecs[15] = vec_t'(12'b0000_0000_0000); // all hold
    vecs[16] = vec_t'(12'b0001_0001_0100); // set SR, then pulse d between edges
    vecs[17] = vec_t'(12'b0000_0000_0100); // pulse must not reach q_d
    vecs[18] = vec_t'(12'b0100_1100_1010);
    vecs[19] = vec_t'(12'b0000_0000_1000);
    vecs[20] = vec_t'(12'b0011_1110_0011); // SR forbidden holds 0, k clears

    rst = 1'b1;
    {j, k, s, r, d, t} = '0;
    for (int unsigned i = 0; i < NVEC; i++) begin
      if (i != 0) @(negedge clk);
      rst = vecs[i].rst;
      j = vecs[i].j;  k = vecs[i].k;
      s = vecs[i].s;  r = vecs[i].r;
      d = vecs[i].d;  t = vecs[i].t;
      @(posedge clk);
      sb_q.push_back('{jk: vecs[i].ejk, sr: vecs[i].esr, dd: vecs[i].ed,
                       tt: vecs[i].et, idx: i});
      if (vecs[i].glitch) begin
        #3 d = ~d;
        #4 d = ~d;
      end
    end
    repeat (2) @(posedge clk);
    #2;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain left=%0d expected=0", sb_q.size());
    end
    stim_done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Monitor: after each edge, compare the DUT against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check1("q_jk",  e.idx, q_jk[0],  e.jk);
        check1("qb_jk", e.idx, qb_jk[0], ~e.jk);
        check1("q_sr",  e.idx, q_sr[0],  e.sr);
        check1("qb_sr", e.idx, qb_sr[0], ~e.sr);
        check1("q_d",   e.idx, q_d[0],   e.dd);
        check1("qb_d",  e.idx, qb_d[0],  ~e.dd);
        check1("q_t",   e.idx, q_t[0],   e.tt);
        check1("qb_t",  e.idx, qb_t[0],  ~e.tt);
        n_checks++;
        if ($isunknown({q_jk, qb_jk, q_sr, qb_sr, q_d, qb_d, q_t, qb_t})) begin
          n_fail++;
          $display("FAIL no_x vec=%0d actual=%b expected=no X", e.idx,
                   {q_jk, qb_jk, q_sr, qb_sr, q_d, qb_d, q_t, qb_t});
        end
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #20000;
    if (!stim_done) begin
      n_fail++;
      $display("FAIL timeout actual=not finished expected=finished");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "timeout");
    end
  end

endmodule
